program_counter: RTL and testbench

//   12-bit program counter for the nibble-processor fetch path.

---
 rtl/program_counter_if.sv | 22 ++
 rtl/program_counter.sv | 31 +++
 tb/tb_program_counter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Fetch-path bus between the sequencer (master) and the program counter (slave).
// enable/newaddr are a sampled strobe pair: whatever they hold at a rising clk edge is
// acted on for that edge alone; there is no ready, and the slave accepts every edge.
interface program_counter_if #(
    parameter int WIDTH = 12
);
    logic             enable;
    logic [WIDTH-1:0] newaddr;
    logic [WIDTH-1:0] addr;

    modport master (
        output enable,
        output newaddr,
        input  addr
    );

    modport slave (
        input  enable,
        input  newaddr,
        output addr
    );
endinterface

// File: rtl/program_counter.sv
// 12-bit instruction-address register: loads a jump target on enable, otherwise counts
// up modulo 2^WIDTH. Asynchronous active-low reset returns it to RESET_ADDR.
module program_counter #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              Rst,
    program_counter_if.slave  bus
);
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;

    // Carry out of the increment is dropped on purpose so FFF wraps to 000.
    always_comb begin
        addr_d = addr_q + {{(WIDTH-1){1'b0}}, 1'b1};
        if (bus.enable) begin
            addr_d = bus.newaddr;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            addr_q <= RESET_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign bus.addr = addr_q;
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus a randomized run
// checked against an arithmetic reference model.
module tb_program_counter;
  localparam int W = 12;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;
  logic [W-1:0] exp_q[$];

  program_counter_if #(.WIDTH(W)) pc_bus ();

  program_counter #(.WIDTH(W), .RESET_ADDR(12'h000)) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (pc_bus.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic drive(input logic en, input logic [W-1:0] na);
    pc_bus.enable  = en;
    pc_bus.newaddr = na;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 12'h000);
    #2;
    n_cmp++;
    if (pc_bus.addr !== 12'h000) begin
      n_mis++;
      $display("FAIL reset_async: got %h expected 000", pc_bus.addr);
    end
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h000) begin
      n_mis++;
      $display("FAIL reset_hold: got %h expected 000", pc_bus.addr);
    end
  endtask

  task automatic test_increment();
    logic [W-1:0] exp;
    rst_n = 1'b1;
    drive(1'b0, 12'h000);
    exp = 12'h000;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      exp = W'((int'(exp) + 1) % 4096);
      n_cmp++;
      if (pc_bus.addr !== exp) begin
        n_mis++;
        $display("FAIL increment[%0d]: got %h expected %h", i, pc_bus.addr, exp);
      end
    end
  endtask

  task automatic test_load();
    drive(1'b1, 12'b0011_0101_1001);
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h359) begin
      n_mis++;
      $display("FAIL load: got %h expected 359", pc_bus.addr);
    end
    drive(1'b0, 12'h000);
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h35A) begin
      n_mis++;
      $display("FAIL load_then_inc: got %h expected 35a", pc_bus.addr);
    end
  endtask

  task automatic test_reset_mid_count();
    edge_step();
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h35C) begin
      n_mis++;
      $display("FAIL count_to_35c: got %h expected 35c", pc_bus.addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pc_bus.addr !== 12'h000) begin
      n_mis++;
      $display("FAIL reset_mid_count: got %h expected 000", pc_bus.addr);
    end
    rst_n = 1'b1;
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h001) begin
      n_mis++;
      $display("FAIL after_reset_release: got %h expected 001", pc_bus.addr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 12'hFFF);
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'hFFF) begin
      n_mis++;
      $display("FAIL wrap_load: got %h expected fff", pc_bus.addr);
    end
    drive(1'b0, 12'h123);
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'h000) begin
      n_mis++;
      $display("FAIL wrap_inc: got %h expected 000", pc_bus.addr);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 12'hABC);
    // reset asserted exactly at a load edge
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pc_bus.addr !== 12'h000) begin
      n_mis++;
      $display("FAIL reset_at_edge: got %h expected 000", pc_bus.addr);
    end
    for (int i = 0; i < 2; i++) begin
      edge_step();
      n_cmp++;
      if (pc_bus.addr !== 12'h000) begin
        n_mis++;
        $display("FAIL reset_priority[%0d]: got %h expected 000", i, pc_bus.addr);
      end
    end
    rst_n = 1'b1;
    edge_step();
    n_cmp++;
    if (pc_bus.addr !== 12'hABC) begin
      n_mis++;
      $display("FAIL priority_release: got %h expected abc", pc_bus.addr);
    end
  endtask

  // Reference model: pc is an integer counter modulo 4096; a load replaces it.
  task automatic test_random();
    int pc;
    int en;
    int na;
    logic [W-1:0] exp;
    pc = int'(pc_bus.addr);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0: begin
          #1 rst_n = 1'b0;
          #1;
          pc = 0;
          n_cmp++;
          if (pc_bus.addr !== 12'h000) begin
            n_mis++;
            $display("FAIL rand_reset[%0d]: got %h expected 000", i, pc_bus.addr);
          end
          rst_n = 1'b1;
        end
        1: begin
          // enable pulse that is gone before the edge must not load
          drive(1'b1, W'($urandom_range(0, 4095)));
          #2;
          drive(1'b0, W'($urandom_range(0, 4095)));
        end
        default: begin
        end
      endcase
      en = ($urandom_range(0, 2) == 0) ? 1 : 0;
      na = ($urandom_range(0, 3) == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
      drive(en[0], W'(na));
      pc = (en != 0) ? na : (pc + 1) % 4096;
      exp_q.push_back(W'(pc));
      edge_step();
      exp = exp_q.pop_front();
      n_cmp++;
      if (pc_bus.addr !== exp) begin
        n_mis++;
        $display("FAIL random[%0d]: got %h expected %h (en=%0d na=%h)", i, pc_bus.addr, exp, en, na);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_increment();
    test_load();
    test_reset_mid_count();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
